// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   N_IRQ      : number of interrupt lines (matches the core's mie width)
//   CAUSE_BASE : mcause value reported for line 0
//   state_t    : controller FSM states
package irq_pkg;

    localparam int          N_IRQ      = 6;
    localparam logic [31:0] CAUSE_BASE = 32'h8000_0010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/irq_controller_irq_rr_arbiter.sv
// Rotating priority encoder.
//   cand  : candidate request vector
//   ptr   : index searched first; search ascends and wraps to 0
//   valid : at least one candidate is set
//   win   : index of the first set candidate found from ptr
module irq_rr_arbiter #(
    parameter int N_IRQ = 6,
    parameter int IDX_W = 3
) (
    input  logic [N_IRQ-1:0] cand,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] win
);

    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N_IRQ) j = j - N_IRQ;
            if (!valid && cand[j]) begin
                valid = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller in front of the processor core.
// Detects rising edges on the source lines, keeps them pending, picks one
// enabled pending line round-robin and holds it on int_o/mcause_o until the
// core signals completion, then acknowledges and retires that line.
//   clk_i     : clock
//   rst_i     : synchronous reset, active high
//   irq_i     : level interrupt lines (0->1 is an event)
//   mie_i     : enable mask from the core
//   int_rst_i : core has finished the presented interrupt
//   int_o     : interrupt presented to the core
//   mcause_o  : cause of the presented interrupt, 0 when int_o is low
//   irq_ack_o : one-hot, one-cycle acknowledge to the serviced source
module irq_controller #(
    parameter int          N_IRQ      = irq_pkg::N_IRQ,
    parameter logic [31:0] CAUSE_BASE = irq_pkg::CAUSE_BASE
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] irq_ack_o
);

    import irq_pkg::*;

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    state_t           state;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] cand;
    logic [N_IRQ-1:0] retire;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             win_valid;

    assign rise = irq_i & ~irq_q;
    assign cand = pend & mie_i;
    // The serviced line is retired on the edge that leaves DONE.
    assign retire = (state == ST_DONE) ? (N_IRQ'(1) << idx) : '0;

    irq_rr_arbiter #(
        .N_IRQ (N_IRQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .cand  (cand),
        .ptr   (ptr),
        .valid (win_valid),
        .win   (win)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            irq_q     <= '0;
            pend      <= '0;
            ptr       <= '0;
            idx       <= '0;
            int_o     <= 1'b0;
            mcause_o  <= '0;
            irq_ack_o <= '0;
        end else begin
            irq_q     <= irq_i;
            // A fresh rise on the retiring line survives the clear.
            pend      <= (pend & ~retire) | rise;
            irq_ack_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        idx      <= win;
                        int_o    <= 1'b1;
                        mcause_o <= CAUSE_BASE + 32'(win);
                        state    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (int_rst_i) begin
                        int_o     <= 1'b0;
                        mcause_o  <= '0;
                        irq_ack_o <= N_IRQ'(1) << idx;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ptr   <= (idx == IDX_W'(N_IRQ - 1)) ? '0 : idx + 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a random
// phase, all checked cycle by cycle against a behavioural model.
module tb_irq_controller;

    localparam int          N    = 6;
    localparam logic [31:0] BASE = 32'h8000_0010;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   irq_i;
    logic [N-1:0]   mie_i;
    logic           int_rst_i;
    logic           int_o;
    logic [31:0]    mcause_o;
    logic [N-1:0]   irq_ack_o;

    int n_checks = 0;
    int n_fail   = 0;

    irq_controller dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .irq_i     (irq_i),
        .mie_i     (mie_i),
        .int_rst_i (int_rst_i),
        .int_o     (int_o),
        .mcause_o  (mcause_o),
        .irq_ack_o (irq_ack_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: which line the core currently sees (-1 none), which line is being
    // acknowledged this cycle (-1 none), pending flags, previous levels and
    // the line the next search starts from.
    bit m_prev [N];
    bit m_pend [N];
    int m_ptr;
    int m_cur;
    int m_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 0;
            m_pend[i] = 0;
        end
        m_ptr = 0;
        m_cur = -1;
        m_ack = -1;
    endtask

    // Advance the model by one clock using the inputs now on the pins.
    task automatic model_tick();
        bit n_pend [N];
        int n_cur, n_ack;
        if (rst_i) begin
            model_clear();
            return;
        end
        for (int i = 0; i < N; i++) n_pend[i] = m_pend[i];
        if (m_ack >= 0) begin
            n_pend[m_ack] = 0;
            m_ptr = (m_ack + 1) % N;
        end
        for (int i = 0; i < N; i++)
            if (irq_i[i] && !m_prev[i]) n_pend[i] = 1;
        n_cur = -1;
        n_ack = -1;
        if (m_cur >= 0) begin
            if (int_rst_i) n_ack = m_cur;
            else           n_cur = m_cur;
        end else if (m_ack < 0) begin
            for (int k = 0; k < N; k++) begin
                int line;
                line = (m_ptr + k) % N;
                if (n_cur < 0 && m_pend[line] && mie_i[line]) n_cur = line;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = n_pend[i];
            m_prev[i] = irq_i[i];
        end
        m_cur = n_cur;
        m_ack = n_ack;
    endtask

    task automatic step();
        model_tick();
        @(posedge clk_i);
        #1;
        chk("int_o",  {31'd0, int_o}, {31'd0, m_cur >= 0});
        chk("mcause", mcause_o, (m_cur >= 0) ? BASE + 32'(m_cur) : 32'd0);
        chk("ack",    {26'd0, irq_ack_o}, (m_ack >= 0) ? 32'(1) << m_ack : 32'd0);
    endtask

    task automatic wait_int(output int line);
        for (int c = 0; c < 12 && !int_o; c++) step();
        chk("wait_int", {31'd0, int_o}, 32'd1);
        line = int_o ? int'(mcause_o - BASE) : -1;
    endtask

    task automatic complete();
        int_rst_i = 1'b1;
        step();
        int_rst_i = 1'b0;
        step();
    endtask

    initial begin
        int line;
        model_clear();
        rst_i = 1'b1; irq_i = '0; mie_i = '0; int_rst_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        chk("rst_pend", {26'd0, dut.pend}, 32'd0);
        step();

        // Single event on line 2: int_o two cycles after the rise.
        mie_i = 6'h3F; irq_i[2] = 1'b1;
        step();
        chk("lat1_int", {31'd0, int_o}, 32'd0);
        step();
        chk("lat2_int", {31'd0, int_o}, 32'd1);
        chk("lat2_cause", mcause_o, 32'h8000_0012);
        step();
        int_rst_i = 1'b1; step(); int_rst_i = 1'b0;
        chk("ack_l2", {26'd0, irq_ack_o}, 32'b000100);
        chk("ack_int", {31'd0, int_o}, 32'd0);
        step();
        chk("ack_one", {26'd0, irq_ack_o}, 32'd0);
        irq_i[2] = 1'b0; step();

        // Masked line waits, then fires one cycle after being enabled.
        mie_i = '0; irq_i[0] = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("mask_int", {31'd0, int_o}, 32'd0);
        mie_i[0] = 1'b1; step();
        chk("unmask_cause", mcause_o, 32'h8000_0010);
        complete();
        irq_i[0] = 1'b0; mie_i = 6'h3F; step();

        // Round robin over 1,3,4; line 1 re-raised while 3 is serviced.
        irq_i = 6'b011010;
        wait_int(line); chk("rr_first", 32'(line), 32'd1); complete();
        irq_i[1] = 1'b0;
        wait_int(line); chk("rr_second", 32'(line), 32'd3);
        irq_i[1] = 1'b1; step();
        complete();
        wait_int(line); chk("rr_third", 32'(line), 32'd4); complete();
        wait_int(line); chk("rr_wrap", 32'(line), 32'd1); complete();
        irq_i = '0; step();

        // Line 5 rises again in its own DONE cycle: set beats clear.
        irq_i[5] = 1'b1;
        wait_int(line); chk("sc_first", 32'(line), 32'd5);
        irq_i[5] = 1'b0; step();
        int_rst_i = 1'b1; step(); int_rst_i = 1'b0;
        irq_i[5] = 1'b1; step();
        chk("sc_gap", {31'd0, int_o}, 32'd0);
        wait_int(line); chk("sc_again", 32'(line), 32'd5); complete();
        irq_i = '0; step();

        // Outputs hold while mie changes; int_rst in idle does nothing.
        irq_i[3] = 1'b1;
        wait_int(line);
        mie_i = '0; step(); mie_i = 6'h15; step();
        chk("stab_cause", mcause_o, 32'h8000_0013);
        mie_i = 6'h3F; complete();
        int_rst_i = 1'b1; step(); step(); int_rst_i = 1'b0;
        chk("idle_rst_ack", {26'd0, irq_ack_o}, 32'd0);
        irq_i = '0; step();

        // Reset while active drops the interrupt with no ack.
        irq_i[0] = 1'b1;
        wait_int(line);
        rst_i = 1'b1; step(); rst_i = 1'b0;
        chk("midrst_int", {31'd0, int_o}, 32'd0);
        chk("midrst_pend", {26'd0, dut.pend}, 32'd0);
        chk("midrst_ack", {26'd0, irq_ack_o}, 32'd0);
        irq_i = '0; step();
        irq_i[4] = 1'b1; step(); step();
        chk("postrst_cause", mcause_o, 32'h8000_0014);
        complete();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) irq_i[i] = ~irq_i[i];
            if ($urandom_range(0, 15) == 0) mie_i = N'($urandom);
            int_rst_i = ($urandom_range(0, 3) == 0);
            rst_i     = ($urandom_range(0, 199) == 0);
            step();
            chk("rnd_pend", {26'd0, dut.pend}, {26'd0, pend_vec()});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
